// File: rtl/bisection_pkg.sv
// Shared types and arithmetic helpers for the bisection current controller.
// The helpers work on a fixed 33-bit signed width, which covers WIDTH up to 31.
package bisection_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        EVAL    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int MATH_W = 33;

    // a + (b-a)/2 never exceeds b, so no intermediate overflow for a <= b
    function automatic logic signed [MATH_W-1:0] midpoint(
        input logic signed [MATH_W-1:0] a,
        input logic signed [MATH_W-1:0] b
    );
        logic signed [MATH_W-1:0] span;
        span = b - a;
        return a + (span >>> 1);
    endfunction

    function automatic logic signed [MATH_W-1:0] abs_diff(
        input logic signed [MATH_W-1:0] x,
        input logic signed [MATH_W-1:0] y
    );
        logic signed [MATH_W-1:0] d;
        d = x - y;
        return (d < 0) ? -d : d;
    endfunction

endpackage

// File: rtl/bisection_settle_timer.sv
// Loadable down-counter that holds i_ref steady for SETTLE_CYC cycles
// before a measurement is requested; zero flags the last settle cycle.
module bisection_settle_timer #(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_V;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bisection_ctrl.sv
// Bisection search on the DAC reference current so that the measured Q
// lands within a runtime tolerance of the requested value.
module bisection_ctrl
    import bisection_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int SETTLE_CYC = 4,
    parameter int MAX_ITER   = WIDTH + 1,
    parameter int ITER_W     = $clog2(MAX_ITER + 1),
    parameter int POLARITY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  desired_q,
    input  logic [WIDTH-1:0]  lo_bound,
    input  logic [WIDTH-1:0]  hi_bound,
    input  logic [WIDTH-1:0]  tol,
    input  logic              meas_valid,
    input  logic [WIDTH-1:0]  measured_q,
    output logic [WIDTH-1:0]  i_ref,
    output logic              meas_req,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              fail,
    output logic [ITER_W-1:0] iter_count
);

    localparam logic POL = (POLARITY != 0);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
    localparam logic signed [WIDTH:0] ONE   = $signed({{WIDTH{1'b0}}, 1'b1});

    function automatic logic signed [MATH_W-1:0] ext(input logic [WIDTH-1:0] v);
        return MATH_W'($signed({1'b0, v}));
    endfunction

    state_t state, state_nxt;

    logic signed [WIDTH:0] a_q, b_q, a_nxt, b_nxt, i_ref_s;
    logic [WIDTH-1:0] des_q, tol_q, meas_q, mid_start, mid_eval;
    logic bad_bounds, within_tol, last_iter, exhausted, need_more;
    logic accept_start, capture, evaluating, meas_req_set;
    logic timer_load, timer_en, timer_zero;

    bisection_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (timer_en),
        .zero (timer_zero)
    );

    // Interval bookkeeping: bounds are signed so stepping below 0 yields -1
    always_comb begin
        bad_bounds = lo_bound > hi_bound;
        mid_start  = WIDTH'(midpoint(ext(lo_bound), ext(hi_bound)));
        i_ref_s    = $signed({1'b0, i_ref});
        need_more  = (meas_q < des_q) ^ POL;
        a_nxt      = need_more ? (i_ref_s + ONE) : a_q;
        b_nxt      = need_more ? b_q : (i_ref_s - ONE);
        mid_eval   = WIDTH'(midpoint(MATH_W'(a_nxt), MATH_W'(b_nxt)));
        within_tol = abs_diff(ext(meas_q), ext(des_q)) <= ext(tol_q);
        last_iter  = (iter_count == ITER_LAST);
        exhausted  = a_nxt > b_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) state_nxt = bad_bounds ? DONE : SETTLE;
                end
                SETTLE: begin
                    if (timer_zero) state_nxt = MEASURE;
                end
                MEASURE: begin
                    if (meas_valid && !meas_req) state_nxt = EVAL;
                end
                EVAL: begin
                    if (within_tol || last_iter || exhausted) state_nxt = DONE;
                    else state_nxt = SETTLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // meas_req is high only in the first MEASURE cycle, which masks a coincident meas_valid
    always_comb begin
        busy         = (state == SETTLE) || (state == MEASURE) || (state == EVAL);
        done         = (state == DONE);
        accept_start = !abort && start && ((state == IDLE) || (state == DONE));
        capture      = !abort && (state == MEASURE) && meas_valid && !meas_req;
        evaluating   = !abort && (state == EVAL);
        meas_req_set = !abort && (state == SETTLE) && timer_zero;
        timer_load   = (state_nxt == SETTLE) && (state != SETTLE);
        timer_en     = (state == SETTLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_ref      <= '0;
            meas_req   <= 1'b0;
            converged  <= 1'b0;
            fail       <= 1'b0;
            iter_count <= '0;
        end else begin
            meas_req <= meas_req_set;
            if (abort) begin
                converged <= 1'b0;
                fail      <= 1'b0;
            end else if (accept_start) begin
                converged  <= 1'b0;
                fail       <= bad_bounds;
                iter_count <= '0;
                if (!bad_bounds) i_ref <= mid_start;
            end else if (evaluating) begin
                if (iter_count != ITER_MAX) iter_count <= iter_count + 1'b1;
                if (within_tol) converged <= 1'b1;
                else if (last_iter || exhausted) fail <= 1'b1;
                else i_ref <= mid_eval;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_start) begin
            des_q <= desired_q;
            tol_q <= tol;
            a_q   <= $signed({1'b0, lo_bound});
            b_q   <= $signed({1'b0, hi_bound});
        end else if (capture) begin
            meas_q <= measured_q;
        end else if (evaluating && !within_tol && !last_iter) begin
            a_q <= a_nxt;
            b_q <= b_nxt;
        end
    end

endmodule
